cmd_credit_arbiter: RTL and testbench

Parametrised command arbiter with credit accounting for the AFU-control command path. It generalises the fixed read/write credit split and the fixed buffer priority order to `NUM_CHANNELS` command sources. Sources draw from one shared credit pool, subject to a per-channel outstanding cap. It sits between the per-class command buffers (restart, WED, prefetch, read, write) and the PSL command interface. Credits are returned on PSL responses.

---
 rtl/cmd_credit_arbiter.sv | 144 ++++++++++++++
 tb/tb_cmd_credit_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_credit_arbiter.sv
// Fixed-priority command arbiter drawing from a shared credit pool with per-channel caps.
// Optional anti-starvation ageing is enabled by defining CMD_CREDIT_STARVE_GUARD_EN.
module cmd_credit_arbiter #(
    parameter int unsigned NUM_CHANNELS       = 6,
    parameter int unsigned CREDITS_TOTAL      = 64,
    parameter int unsigned CHANNEL_CREDIT_MAX = 32,
    parameter int unsigned CH_W               = $clog2(NUM_CHANNELS),
    parameter int unsigned CREDIT_W           = $clog2(CREDITS_TOTAL + 1),
    parameter int unsigned STARVE_LIMIT       = 16
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_CHANNELS-1:0] req_valid,
    output logic [NUM_CHANNELS-1:0] req_ready,
    output logic                    grant_valid,
    output logic [CH_W-1:0]         grant_channel,
    input  logic                    rsp_valid,
    input  logic [CH_W-1:0]         rsp_channel,
    output logic [CREDIT_W-1:0]     credits_available,
    output logic                    idle,
    output logic                    credit_error
);

    if (CREDITS_TOTAL > 64 || CHANNEL_CREDIT_MAX > CREDITS_TOTAL || STARVE_LIMIT == 0) begin : g_bad_params
        $error("cmd_credit_arbiter: illegal parameter combination");
    end

    logic [CREDIT_W-1:0]     pool;
    logic [CREDIT_W-1:0]     pool_next;
    logic [CREDIT_W-1:0]     outstanding [NUM_CHANNELS];
    logic [CREDIT_W-1:0]     out_next    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] rsp_hit;
    logic [NUM_CHANNELS-1:0] eligible;
    logic [NUM_CHANNELS-1:0] starved;
    logic [NUM_CHANNELS-1:0] pick;
    logic [NUM_CHANNELS-1:0] grant_oh;
    logic [CH_W-1:0]         grant_idx;
    logic                    rsp_legal;
    logic                    rsp_illegal;
    logic                    pool_ok;
    logic                    transfer;
    logic                    found;
    logic                    idle_next;

`ifdef CMD_CREDIT_STARVE_GUARD_EN
    localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [AGE_W-1:0] age [NUM_CHANNELS];

    always_comb begin
        starved = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            starved[i] = eligible[i] && (age[i] == AGE_W'(STARVE_LIMIT));
        end
    end

    // Age counts cycles a channel was eligible but lost; saturates at the limit.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (rst || grant_oh[i] || !req_valid[i]) begin
                age[i] <= '0;
            end else if (eligible[i] && age[i] != AGE_W'(STARVE_LIMIT)) begin
                age[i] <= age[i] + AGE_W'(1);
            end
        end
    end
`else
    assign starved = '0;
`endif

    // Response legality, eligibility (same-cycle returns count toward pool and cap), priority pick.
    always_comb begin
        rsp_hit     = '0;
        eligible    = '0;
        grant_oh    = '0;
        grant_idx   = '0;
        found       = 1'b0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            rsp_hit[i] = rsp_valid && (rsp_channel == CH_W'(i)) && (outstanding[i] != '0);
        end
        rsp_legal   = |rsp_hit;
        rsp_illegal = rsp_valid && !rsp_legal;
        pool_ok     = (pool != '0) || rsp_legal;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            eligible[i] = !rst && enable && req_valid[i] && pool_ok &&
                          ((outstanding[i] - CREDIT_W'(rsp_hit[i])) < CREDIT_W'(CHANNEL_CREDIT_MAX));
        end
        pick = (|starved) ? starved : eligible;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (!found && pick[i]) begin
                found       = 1'b1;
                grant_oh[i] = 1'b1;
                grant_idx   = CH_W'(i);
            end
        end
        req_ready = grant_oh;
        transfer  = found;
    end

    // Next-state accounting; a grant and a legal return in one cycle cancel on the pool.
    always_comb begin
        pool_next = pool;
        if (transfer && !rsp_legal) begin
            pool_next = pool - CREDIT_W'(1);
        end else if (!transfer && rsp_legal) begin
            pool_next = pool + CREDIT_W'(1);
        end
        idle_next = (pool_next == CREDIT_W'(CREDITS_TOTAL));
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            out_next[i] = outstanding[i] + CREDIT_W'(grant_oh[i]) - CREDIT_W'(rsp_hit[i]);
            if (out_next[i] != '0) begin
                idle_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            pool              <= CREDIT_W'(CREDITS_TOTAL);
            grant_valid       <= 1'b0;
            grant_channel     <= '0;
            credits_available <= CREDIT_W'(CREDITS_TOTAL);
            idle              <= 1'b1;
            credit_error      <= 1'b0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                outstanding[i] <= '0;
            end
        end else begin
            pool              <= pool_next;
            grant_valid       <= transfer;
            credits_available <= pool_next;
            idle              <= idle_next;
            credit_error      <= credit_error | rsp_illegal;
            if (transfer) begin
                grant_channel <= grant_idx;
            end
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                outstanding[i] <= out_next[i];
            end
        end
    end

endmodule

// File: tb/tb_cmd_credit_arbiter.sv
// Directed bench for cmd_credit_arbiter; define CMD_CREDIT_STARVE_GUARD_EN to check the ageing variant.
module tb_cmd_credit_arbiter;

    logic       clock = 1'b0;
    logic       rst;
    logic       enable;
    logic [5:0] req_valid;
    logic [5:0] req_ready;
    logic       grant_valid;
    logic [2:0] grant_channel;
    logic       rsp_valid;
    logic [2:0] rsp_channel;
    logic [6:0] credits_available;
    logic       idle;
    logic       credit_error;

    int tests = 0;
    int fails = 0;
    int grants;
    int ch5_grant_cycle;

    cmd_credit_arbiter dut (
        .clock             (clock),
        .rst               (rst),
        .enable            (enable),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .grant_valid       (grant_valid),
        .grant_channel     (grant_channel),
        .rsp_valid         (rsp_valid),
        .rsp_channel       (rsp_channel),
        .credits_available (credits_available),
        .idle              (idle),
        .credit_error      (credit_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; req_valid = 6'h3f; rsp_valid = 1'b0; rsp_channel = '0;

        // Reset: two cycles, requests present but nothing granted
        tick(); tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_credits", 32'(credits_available), 32'd64);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_err", 32'(credit_error), 32'd0);
        chk("rst_gv", 32'(grant_valid), 32'd0);
        chk("rst_gch", 32'(grant_channel), 32'd0);
        rst = 1'b0; req_valid = '0;
        #1;
        chk("idle_ready", 32'(req_ready), 32'h0);

        // Priority: channel 1 beats 4 and 5
        req_valid = 6'b110010;
        #1;
        chk("prio_ready", 32'(req_ready), 32'b000010);
        tick();
        req_valid = '0;
        chk("prio_gv", 32'(grant_valid), 32'd1);
        chk("prio_gch", 32'(grant_channel), 32'd1);
        chk("prio_credits", 32'(credits_available), 32'd63);
        chk("prio_idle", 32'(idle), 32'd0);
        rsp_valid = 1'b1; rsp_channel = 3'd1;
        tick();
        rsp_valid = 1'b0;
        chk("ret_gv", 32'(grant_valid), 32'd0);
        chk("ret_credits", 32'(credits_available), 32'd64);
        chk("ret_idle", 32'(idle), 32'd1);

        // Enable low blocks grants
        enable = 1'b0; req_valid = 6'b000001;
        #1;
        chk("en_low_ready", 32'(req_ready), 32'h0);
        tick();
        chk("en_low_gv", 32'(grant_valid), 32'd0);
        enable = 1'b1; req_valid = '0;

        // Per-channel cap on channel 5
        req_valid = 6'b100000; grants = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (grant_valid) grants++;
        end
        chk("cap_grants", 32'(grants), 32'd32);
        chk("cap_ready", 32'(req_ready), 32'h0);
        chk("cap_credits", 32'(credits_available), 32'd32);
        rsp_valid = 1'b1; rsp_channel = 3'd5;
        #1;
        chk("cap_rsp_ready", 32'(req_ready), 32'b100000);
        tick();
        rsp_valid = 1'b0;
        chk("cap_rsp_gv", 32'(grant_valid), 32'd1);
        chk("cap_rsp_gch", 32'(grant_channel), 32'd5);
        chk("cap_rsp_credits", 32'(credits_available), 32'd32);
        grants = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (grant_valid) grants++;
        end
        chk("cap_no_extra", 32'(grants), 32'd0);
        req_valid = '0; rsp_valid = 1'b1; rsp_channel = 3'd5;
        for (int k = 0; k < 32; k++) tick();
        rsp_valid = 1'b0;
        chk("cap_drain_credits", 32'(credits_available), 32'd64);
        chk("cap_drain_idle", 32'(idle), 32'd1);

        // Pool exhaustion by channels 4 and 5, then same-cycle return and grant
        req_valid = 6'b110000;
        for (int k = 0; k < 100 && credits_available != 7'd0; k++) tick();
        chk("exh_credits", 32'(credits_available), 32'd0);
        chk("exh_ready", 32'(req_ready), 32'h0);
        req_valid = 6'b010000; rsp_valid = 1'b1; rsp_channel = 3'd4;
        #1;
        chk("exh_swap_ready", 32'(req_ready), 32'b010000);
        tick();
        rsp_valid = 1'b0; req_valid = '0;
        chk("exh_swap_gv", 32'(grant_valid), 32'd1);
        chk("exh_swap_gch", 32'(grant_channel), 32'd4);
        chk("exh_swap_credits", 32'(credits_available), 32'd0);
        rsp_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            rsp_channel = (k < 32) ? 3'd4 : 3'd5;
            tick();
        end
        rsp_valid = 1'b0;
        chk("exh_drain_credits", 32'(credits_available), 32'd64);
        chk("exh_drain_idle", 32'(idle), 32'd1);
        chk("exh_drain_err", 32'(credit_error), 32'd0);

        // Illegal returns: zero outstanding, then out-of-range channel
        rsp_valid = 1'b1; rsp_channel = 3'd3;
        tick();
        rsp_valid = 1'b0;
        chk("ill3_err", 32'(credit_error), 32'd1);
        chk("ill3_credits", 32'(credits_available), 32'd64);
        tick();
        chk("ill3_sticky", 32'(credit_error), 32'd1);
        rsp_valid = 1'b1; rsp_channel = 3'd7;
        tick();
        rsp_valid = 1'b0;
        chk("ill7_err", 32'(credit_error), 32'd1);
        chk("ill7_credits", 32'(credits_available), 32'd64);
        chk("ill7_idle", 32'(idle), 32'd1);

        // Channels 0 and 5 compete continuously for 20 cycles
        req_valid = 6'b100001; ch5_grant_cycle = 0;
        for (int c = 1; c <= 20; c++) begin
            #1;
`ifdef CMD_CREDIT_STARVE_GUARD_EN
            chk($sformatf("starve_c%0d", c), 32'(req_ready), (c == 17) ? 32'b100000 : 32'b000001);
`else
            chk($sformatf("starve_c%0d", c), 32'(req_ready), 32'b000001);
`endif
            if (req_ready[5] && ch5_grant_cycle == 0) ch5_grant_cycle = c;
            tick();
        end
`ifdef CMD_CREDIT_STARVE_GUARD_EN
        chk("starve_first_ch5", 32'(ch5_grant_cycle), 32'd17);
`else
        chk("starve_first_ch5", 32'(ch5_grant_cycle), 32'd0);
`endif

        // Mid-operation reset discards credits; response in reset cycle ignored
        req_valid = '0; rst = 1'b1; rsp_valid = 1'b1; rsp_channel = 3'd0;
        tick();
        rst = 1'b0; rsp_valid = 1'b0;
        chk("mid_rst_credits", 32'(credits_available), 32'd64);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_err", 32'(credit_error), 32'd0);
        rsp_valid = 1'b1; rsp_channel = 3'd0;
        tick();
        rsp_valid = 1'b0;
        chk("post_rst_ret_err", 32'(credit_error), 32'd1);
        chk("post_rst_ret_credits", 32'(credits_available), 32'd64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
